// File: rtl/ui_pkg.sv
// ui_pkg -- shared types and helpers for the user-interface input blocks.
//
// Contents:
//   ui_db_state_t  state encoding of the ui_debounce FSM
//   cnt_width()    counter width needed to hold the values 0..max_val-1
package ui_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } ui_db_state_t;

    // Counters only ever hold 0..max_val-1 because they are cleared (or the
    // FSM moves on) on the edge that would reach max_val. The result is
    // never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/ui_debounce.sv
// ui_debounce -- push-button debouncer with press/release pulses and
// auto-repeat while held.
//
// signal_in must already be synchronised to clk_dst; at the integration
// level ui_meta_harden sits directly upstream of this block.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive equal samples needed to accept a change (2..65535)
//   REPEAT_DELAY     edges from press acceptance to the first repeat pulse (0 = no repeat)
//   REPEAT_PERIOD    edges between successive repeat pulses (1..65535)
//
// Ports:
//   clk_dst      single clock
//   rst_dst_n    asynchronous active-low reset
//   signal_in    synchronised raw button level
//   btn_level    debounced level (registered)
//   btn_press    one-cycle pulse on an accepted rise
//   btn_release  one-cycle pulse on an accepted fall
//   btn_repeat   one-cycle auto-repeat pulse while held
module ui_debounce
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic clk_dst,
    input  logic rst_dst_n,
    input  logic signal_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int RUN_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    // "Last" values: the counter holds this on the edge that completes the run.
    localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE     = RUN_W'(1);
    localparam bit                REPEAT_EN   = (REPEAT_DELAY != 0);

    ui_db_state_t      state_reg, state_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              level_reg, level_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              repeat_reg, repeat_next;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_dst or negedge rst_dst_n) begin
        if (!rst_dst_n) begin
            state_reg   <= IDLE;
            run_reg     <= '0;
            hold_reg    <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            run_reg     <= run_next;
            hold_reg    <= hold_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        run_next     = run_reg;
        hold_next    = hold_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (signal_in) begin
                    state_next = PRESS_WAIT;
                    run_next   = RUN_ONE;
                end else begin
                    run_next   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!signal_in) begin
                    state_next = IDLE;
                    run_next   = '0;
                end else if (run_reg == RUN_LAST) begin
                    state_next = HELD;
                    run_next   = '0;
                    hold_next  = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    run_next   = run_inc(run_reg);
                end
            end

            HELD: begin
                if (!signal_in) begin
                    // Hold counter is left untouched: repeat timing freezes.
                    state_next  = RELEASE_WAIT;
                    run_next    = RUN_ONE;
                end else if (REPEAT_EN && hold_reg == DELAY_LAST) begin
                    state_next  = REPEAT;
                    hold_next   = '0;
                    repeat_next = 1'b1;
                end else begin
                    // With auto-repeat disabled this just saturates.
                    hold_next   = hold_inc(hold_reg);
                end
            end

            REPEAT: begin
                if (!signal_in) begin
                    state_next  = RELEASE_WAIT;
                    run_next    = RUN_ONE;
                end else if (hold_reg == PERIOD_LAST) begin
                    hold_next   = '0;
                    repeat_next = 1'b1;
                end else begin
                    hold_next   = hold_inc(hold_reg);
                end
            end

            RELEASE_WAIT: begin
                if (signal_in) begin
                    // A glitch, not a new press: restart the full repeat delay.
                    state_next   = HELD;
                    run_next     = '0;
                    hold_next    = '0;
                end else if (run_reg == RUN_LAST) begin
                    state_next   = IDLE;
                    run_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    run_next     = run_inc(run_reg);
                end
            end

            default: begin
                state_next = IDLE;
                run_next   = '0;
                hold_next  = '0;
                level_next = 1'b0;
            end
        endcase
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_repeat  = repeat_reg;

endmodule

// File: tb/tb_ui_debounce.sv
// tb_ui_debounce -- self-checking bench for ui_debounce with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
//
// A behavioural model tracks the accepted level, the length of the current
// run of samples that disagree with it, and the number of high edges since
// the press (or glitch) that started the current hold; repeat pulses are
// derived arithmetically from that hold count.
module tb_ui_debounce;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 5;

    logic clk_dst   = 1'b0;
    logic rst_dst_n = 1'b1;
    logic signal_in = 1'b0;
    logic btn_level, btn_press, btn_release, btn_repeat;

    ui_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk_dst    (clk_dst),
        .rst_dst_n  (rst_dst_n),
        .signal_in  (signal_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk_dst = ~clk_dst;

    int n_total = 0;
    int n_pass  = 0;

    // Model state
    logic m_level, m_press, m_release, m_repeat;
    int   m_run, m_hold;

    // Observed-event bookkeeping for directed timing checks
    int edge_no = 0;
    int n_press = 0;
    int n_release = 0;
    int last_press_edge = -1;
    int last_release_edge = -1;
    int rep_edges[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
        m_run = 0; m_hold = 0;
    endtask

    task automatic model_edge(input logic v);
        m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
        if (!m_level) begin
            if (v) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = 1'b1; m_press = 1'b1; m_run = 0; m_hold = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (!v) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = 1'b0; m_release = 1'b1; m_run = 0;
                end
            end else if (m_run > 0) begin
                m_run = 0; m_hold = 0;
            end else begin
                m_hold++;
                if (DELAY != 0 && m_hold >= DELAY && (m_hold - DELAY) % PERIOD == 0)
                    m_repeat = 1'b1;
            end
        end
    endtask

    // One transaction: drive v, take one clock edge, compare all outputs.
    task automatic step(input logic v);
        signal_in = v;
        @(posedge clk_dst);
        edge_no++;
        model_edge(v);
        #1;
        $display("edge=%0d in=%0b level=%0b press=%0b release=%0b repeat=%0b",
                 edge_no, v, btn_level, btn_press, btn_release, btn_repeat);
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_release);
        chk("repeat",  btn_repeat,  m_repeat);
        if (btn_press === 1'b1)   begin n_press++;   last_press_edge = edge_no;   end
        if (btn_release === 1'b1) begin n_release++; last_release_edge = edge_no; end
        if (btn_repeat === 1'b1)  rep_edges.push_back(edge_no);
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_level"},   btn_level,   1'b0);
        chk({tag, "_press"},   btn_press,   1'b0);
        chk({tag, "_release"}, btn_release, 1'b0);
        chk({tag, "_repeat"},  btn_repeat,  1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, np, nr, k;
        logic [7:0] bounce;
        model_reset();

        // Reset state
        #1 rst_dst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        @(posedge clk_dst);
        @(posedge clk_dst);
        #2 rst_dst_n = 1'b1;
        steps(1'b0, 2);

        // Clean press, then release
        base = edge_no; np = n_press;
        steps(1'b1, 6);
        chk("clean_press_count", n_press - np, 1);
        chk("clean_press_edge", last_press_edge - base, DEB);
        chk("clean_level_high", btn_level, 1'b1);
        base = edge_no; nr = n_release;
        steps(1'b0, 5);
        chk("clean_release_count", n_release - nr, 1);
        chk("clean_release_edge", last_release_edge - base, DEB);

        // Bounce 1,1,1,0,1,1,1,1
        bounce = 8'b1111_0111;
        base = edge_no; np = n_press;
        for (int i = 0; i < 8; i++) step(bounce[i]);
        chk("bounce_press_count", n_press - np, 1);
        chk("bounce_press_edge", last_press_edge - base, 8);
        steps(1'b0, 5);

        // Hold for 30 edges: repeats after edges 14, 19, 24, 29
        base = edge_no; rep_edges.delete();
        steps(1'b1, 30);
        chk("hold_repeat_count", rep_edges.size(), 4);
        for (int i = 0; i < 4 && i < rep_edges.size(); i++)
            chk("hold_repeat_edge", rep_edges[i] - base, 14 + 5 * i);

        // Release glitch in REPEAT: 2 low, back high -> repeat 10 edges later
        nr = n_release;
        steps(1'b0, 2);
        step(1'b1);
        k = edge_no; rep_edges.delete();
        steps(1'b1, 11);
        chk("glitch_no_release", n_release - nr, 0);
        chk("glitch_repeat_seen", rep_edges.size() > 0, 1'b1);
        if (rep_edges.size() > 0)
            chk("glitch_repeat_edge", rep_edges[0] - k, DELAY);

        // Release: 4 low samples
        base = edge_no; nr = n_release; rep_edges.delete();
        steps(1'b0, 4);
        chk("release_edge", last_release_edge - base, DEB);
        chk("release_level_low", btn_level, 1'b0);
        chk("release_no_repeat", rep_edges.size(), 0);
        steps(1'b0, 2);

        // Asynchronous reset in REPEAT, input held high through release
        steps(1'b1, DEB + DELAY + 2);
        nr = n_release;
        #2 rst_dst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        @(posedge clk_dst);
        #1 chk_outputs_zero("reset_hold");
        model_reset();
        #2 rst_dst_n = 1'b1;
        base = edge_no; np = n_press;
        steps(1'b1, DEB);
        chk("post_reset_press_edge", last_press_edge - base, DEB);
        chk("post_reset_press_count", n_press - np, 1);
        chk("post_reset_no_release", n_release - nr, 0);
        steps(1'b0, DEB + 1);

        // Randomised segments checked against the model every edge
        for (int s = 0; s < 60; s++) begin
            int len;
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 35))
                                               : int'($urandom_range(1, 7));
            steps(lvl, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
